// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the pixel FIFO drain path: FSM state encoding and
// the default geometry used by the FIFO wrapper and the write controller.
package fifo_burst_reader_pkg;

  localparam int DEF_DATA_WIDTH  = 16;  // pixel word width
  localparam int DEF_LEVEL_WIDTH = 12;  // 2048-deep FIFO level, depth-width + 1
  localparam int DEF_BURST_LEN   = 64;  // beats per full DDR write burst
  localparam int DEF_LEN_WIDTH   = 8;   // holds any burst length 1..255

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // watching the water level
    REQ  = 2'd1,  // burst request outstanding
    XFER = 2'd2   // popping and streaming the granted beats
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_skid_buf.sv
// Two-entry valid/ready buffer that absorbs the one-cycle FIFO read latency,
// so pops can be issued before the downstream consumer has taken the
// previous word.
module burst_skid_buf #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] entry [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  assign head_data = entry[rd_ptr];

  // Ring of two entries with an occupancy count; push and pop together keep occ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the two storage words are reset so the stream data port reads 0
      // after reset; a larger RAM would normally be left unreset.
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side drain engine for the line FIFO: requests DDR write bursts when a
// full burst (or a flushed remainder) is buffered, then pops exactly the
// granted words and streams them out with a last marker.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LEVEL_WIDTH = DEF_LEVEL_WIDTH,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  input  logic                   flush,
  output logic                   burst_req,
  output logic [LEN_WIDTH-1:0]   burst_len,
  input  logic                   burst_ack,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy
);

  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [LEN_WIDTH-1:0]   FULL_LEN   = LEN_WIDTH'(BURST_LEN);

  state_t               state;
  logic [LEN_WIDTH-1:0] rd_left;     // pops still to issue in this burst
  logic [LEN_WIDTH-1:0] beat_left;   // beats still to hand over in this burst
  logic                 flush_pend;
  logic                 inflight;    // a pop was issued last cycle
  logic [1:0]           occ;
  logic                 handshake;
  logic [2:0]           slots_used;

  assign handshake = m_valid & m_ready;
  assign m_valid   = (occ != 2'd0);
  assign m_last    = m_valid & (beat_left == LEN_WIDTH'(1));
  assign busy      = (state != IDLE) | flush_pend;

  burst_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(fifo_rd_data),
    .pop      (handshake),
    .head_data(m_data),
    .occ      (occ)
  );

  // Pop gating: a beat leaving this cycle frees its slot, which keeps the
  // pipeline at one word per clock while never overfilling the two entries.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    fifo_rd_en = 1'b0;
    slots_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, handshake};
    if (state == XFER && rd_left != '0 && !fifo_rd_empty && slots_used < 3'd2) begin
      fifo_rd_en = 1'b1;
    end
  end

  // Burst FSM with its counters, flush capture and registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // read in this block sees the value from before the clock edge.
      state      <= IDLE;
      burst_req  <= 1'b0;
      burst_len  <= '0;
      rd_left    <= '0;
      beat_left  <= '0;
      flush_pend <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (fifo_rd_en) begin
        rd_left <= rd_left - LEN_WIDTH'(1);
      end
      if (handshake) begin
        beat_left <= beat_left - LEN_WIDTH'(1);
      end

      case (state)
        IDLE: begin
          if (fifo_rd_water_level >= FULL_LEVEL) begin
            state     <= REQ;
            burst_req <= 1'b1;
            burst_len <= FULL_LEN;
          end else if (flush_pend) begin
            flush_pend <= 1'b0;
            if (fifo_rd_water_level != '0) begin
              state     <= REQ;
              burst_req <= 1'b1;
              burst_len <= fifo_rd_water_level[LEN_WIDTH-1:0];
            end
          end
        end
        REQ: begin
          if (burst_ack) begin
            state     <= XFER;
            burst_req <= 1'b0;
            rd_left   <= burst_len;
            beat_left <= burst_len;
          end
        end
        XFER: begin
          if (handshake && m_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A new flush always wins over the clear above, so a pulse landing on
      // the IDLE decision cycle is serviced on a later pass.
      if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a behavioural FIFO feeds index-valued
// words, and each burst is checked for length, order, last marker, stall
// stability, latency and exact pop count.
module tb_fifo_burst_reader;

  localparam int DW  = 16;
  localparam int LW  = 12;
  localparam int BL  = 64;
  localparam int LNW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty;
  logic [LW-1:0] fifo_rd_water_level;
  logic          flush = 1'b0;
  logic          burst_req;
  logic [LNW-1:0] burst_len;
  logic          burst_ack = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // FIFO model: mem[i] holds i, so word order is directly checkable.
  logic [DW-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_count = 0;
  logic [DW-1:0] next_exp = '0;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .LEVEL_WIDTH(LW),
    .BURST_LEN  (BL),
    .LEN_WIDTH  (LNW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_empty      (fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .flush              (flush),
    .burst_req          (burst_req),
    .burst_len          (burst_len),
    .burst_ack          (burst_ack),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_last             (m_last),
    .busy               (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  assign fifo_rd_empty       = (wr_ptr == rd_ptr);
  assign fifo_rd_water_level = LW'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      check("underrun", {31'b0, fifo_rd_empty}, 32'd0);
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
      pop_count    <= pop_count + 1;
    end
  end

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = 16'(wr_ptr);
      wr_ptr++;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Waits for a request, acks it after ack_dly cycles and consumes the burst.
  task automatic run_burst(input int len, input int ack_dly, input bit rnd,
                           input int flush_beat, input bit busy_after, input string tag);
    int cyc;
    int beats;
    int gaps;
    int first_cyc;
    int pops0;
    bit stalled;
    logic [DW-1:0] held_d;
    logic held_last;
    logic rdy;

    cyc = 0;
    while (!burst_req && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_req"}, {31'b0, burst_req}, 32'd1);
    check({tag, "_len"}, {24'b0, burst_len}, 32'(len));
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    pops0 = pop_count;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      check({tag, "_req_hold"}, {23'b0, burst_req, burst_len}, {23'b0, 1'b1, 8'(len)});
    end
    check({tag, "_no_pop_before_ack"}, 32'(pop_count - pops0), 32'd0);
    burst_ack = 1'b1;
    @(negedge clk);
    burst_ack = 1'b0;
    check({tag, "_req_drop"}, {31'b0, burst_req}, 32'd0);

    beats = 0; gaps = 0; first_cyc = -1; stalled = 1'b0; cyc = 0;
    held_d = '0; held_last = 1'b0;
    while (beats < len && cyc < 2000) begin
      if (stalled) begin
        check({tag, "_stall_hold"}, {15'b0, m_valid, m_data}, {15'b0, 1'b1, held_d});
        check({tag, "_stall_last"}, {31'b0, m_last}, {31'b0, held_last});
      end
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (!rnd && first_cyc >= 0 && !m_valid) gaps++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready = rdy;
      if (m_valid && rdy) begin
        check({tag, "_data"}, {16'b0, m_data}, {16'b0, next_exp});
        check({tag, "_last"}, {31'b0, m_last}, {31'b0, (beats == len - 1)});
        next_exp = next_exp + 16'd1;
        beats++;
        if (beats == flush_beat) flush = 1'b1;
      end
      stalled   = m_valid && !rdy;
      held_d    = m_data;
      held_last = m_last;
      @(negedge clk);
      flush = 1'b0;
      cyc++;
    end
    m_ready = 1'b1;
    check({tag, "_beats"}, 32'(beats), 32'(len));
    check({tag, "_first_valid"}, 32'(first_cyc), 32'd2);
    if (!rnd) check({tag, "_gaps"}, 32'(gaps), 32'd0);
    check({tag, "_valid_after"}, {31'b0, m_valid}, 32'd0);
    check({tag, "_busy_after"}, {31'b0, busy}, {31'b0, busy_after});
    check({tag, "_pops"}, 32'(pop_count - pops0), 32'(len));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ppc;
    int beats;
    int cyc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs",
          {21'b0, fifo_rd_en, burst_req, burst_len, m_valid, m_last, busy},
          32'd0);
    check("rst_m_data", {16'b0, m_data}, 32'd0);

    // Full burst, ack two cycles after request, m_ready held high
    load(64);
    rst = 1'b0;
    run_burst(64, 2, 1'b0, -1, 1'b0, "full");

    // Partial level alone does nothing; a flush drains it
    load(10);
    repeat (5) begin
      @(negedge clk);
      check("partial_no_req", {31'b0, burst_req}, 32'd0);
    end
    pulse_flush();
    check("flush10_busy", {31'b0, busy}, 32'd1);
    run_burst(10, 1, 1'b0, -1, 1'b0, "flush10");

    // Flush with empty FIFO: busy for exactly one cycle, no request
    pulse_flush();
    check("flush0_busy_hi", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("flush0_busy_lo", {31'b0, busy}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("flush0_no_req", {30'b0, burst_req, busy}, 32'd0);
    end

    // Random back-pressure during a full burst
    load(64);
    run_burst(64, 0, 1'b1, -1, 1'b0, "stall");
    ppc = pop_count;
    repeat (5) @(negedge clk);
    check("stall_no_extra_pops", 32'(pop_count - ppc), 32'd0);

    // Flush during XFER of a full burst leaves 5 words for a second burst
    load(69);
    run_burst(64, 3, 1'b0, 30, 1'b1, "flushxfer");
    run_burst(5, 2, 1'b0, -1, 1'b0, "tail5");

    // Reset in the middle of a burst
    load(64);
    cyc = 0;
    while (!burst_req && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rstmid_req", {31'b0, burst_req}, 32'd1);
    burst_ack = 1'b1;
    @(negedge clk);
    burst_ack = 1'b0;
    beats = 0; cyc = 0;
    while (beats < 20 && cyc < 200) begin
      if (m_valid) begin
        check("rstmid_data", {16'b0, m_data}, {16'b0, next_exp});
        next_exp = next_exp + 16'd1;
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    #1;
    check("rstmid_outputs",
          {21'b0, fifo_rd_en, burst_req, burst_len, m_valid, m_last, busy},
          32'd0);
    check("rstmid_m_data", {16'b0, m_data}, 32'd0);
    ppc = pop_count;
    repeat (2) begin
      @(negedge clk);
      check("rstmid_hold_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("rstmid_idle", {29'b0, fifo_rd_en, burst_req, m_valid}, 32'd0);
    end
    check("rstmid_no_pops", 32'(pop_count - ppc), 32'd0);

    // Recovery: flush drains whatever the abandoned burst left behind
    next_exp = 16'(rd_ptr);
    pulse_flush();
    run_burst(wr_ptr - rd_ptr, 1, 1'b0, -1, 1'b0, "recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
